div_arbiter: RTL

Round-robin scheduler that shares one blocking, unsigned, iterative divider among several formant-analysis requesters, such as per-formant phi engines. It accepts signed dividend/divisor pairs over a valid/ready handshake and converts them to magnitudes for the divider. It issues one divide at a time and returns the sign-corrected quotient/remainder to the owning requester. It also guards against divide-by-zero and a hung divider.

---
 rtl/div_arbiter_if.sv | 44 ++++
 rtl/div_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter_if.sv
// Requester and divider bus bundle for div_arbiter.
//   slave  : arbiter view (takes requests and divider results, drives grants,
//            divider start and responses)
//   master : environment view (requesters plus the shared divider)
interface div_arbiter_if #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned NUM_REQ = 3
);
  // Requester side
  logic [NUM_REQ-1:0]            req_valid_in;
  logic [NUM_REQ-1:0]            req_ready_out;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_dividend_in;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_divisor_in;

  // Divider side
  logic [WIDTH-1:0]              div_dividend_out;
  logic [WIDTH-1:0]              div_divisor_out;
  logic                          div_valid_out;
  logic [WIDTH-1:0]              div_quotient_in;
  logic [WIDTH-1:0]              div_remainder_in;
  logic                          div_done_in;

  // Response side
  logic [NUM_REQ-1:0]            resp_valid_out;
  logic [WIDTH-1:0]              resp_quotient_out;
  logic [WIDTH-1:0]              resp_remainder_out;
  logic                          resp_err_out;

  modport slave (
    input  req_valid_in, req_dividend_in, req_divisor_in,
    input  div_quotient_in, div_remainder_in, div_done_in,
    output req_ready_out,
    output div_dividend_out, div_divisor_out, div_valid_out,
    output resp_valid_out, resp_quotient_out, resp_remainder_out, resp_err_out
  );

  modport master (
    output req_valid_in, req_dividend_in, req_divisor_in,
    output div_quotient_in, div_remainder_in, div_done_in,
    input  req_ready_out,
    input  div_dividend_out, div_divisor_out, div_valid_out,
    input  resp_valid_out, resp_quotient_out, resp_remainder_out, resp_err_out
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one unsigned iterative divider among NUM_REQ
// signed requesters. Converts operands to magnitudes, issues one divide at a
// time, sign-corrects the result and returns it to the owning requester.
// Divide-by-zero and divider timeout are reported through resp_err_out.
// Ports:
//   clk_in    : clock, all state on rising edge
//   rst_n_in  : asynchronous active-low reset
//   bus       : div_arbiter_if.slave (requests, divider, responses)
module div_arbiter #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned TIMEOUT = 80
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  div_arbiter_if.slave bus
);

  localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned LAST_IDX = NUM_REQ - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               div_valid_q, div_valid_d;
  logic [WIDTH-1:0]   div_dividend_q, div_dividend_d;
  logic [WIDTH-1:0]   div_divisor_q, div_divisor_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]   resp_quotient_q, resp_quotient_d;
  logic [WIDTH-1:0]   resp_remainder_q, resp_remainder_d;
  logic               resp_err_q, resp_err_d;

  logic               winner_found_c;
  logic [IDX_W-1:0]   winner_c;
  logic [IDX_W-1:0]   cand_c;
  logic [NUM_REQ-1:0] grant_oh_c;
  logic [NUM_REQ-1:0] owner_oh_c;
  logic               accept_c;
  logic [WIDTH-1:0]   sel_dividend_c;
  logic [WIDTH-1:0]   sel_divisor_c;
  logic [WIDTH-1:0]   mag_dividend_c;
  logic [WIDTH-1:0]   mag_divisor_c;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    winner_found_c = 1'b0;
    winner_c       = '0;
    cand_c         = last_grant_q;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand_c = (cand_c == IDX_W'(LAST_IDX)) ? '0 : cand_c + 1'b1;
      if (!winner_found_c && bus.req_valid_in[cand_c]) begin
        winner_found_c = 1'b1;
        winner_c       = cand_c;
      end
    end
  end

  assign grant_oh_c = NUM_REQ'(1) << winner_c;
  assign owner_oh_c = NUM_REQ'(1) << owner_q;
  assign accept_c   = (state_q == ST_IDLE) && winner_found_c;

  // Ready is the only combinational output: it must answer in the IDLE cycle
  assign bus.req_ready_out = accept_c ? grant_oh_c : '0;

  // Winner operands and their magnitudes; 2^(WIDTH-1) maps onto itself
  assign sel_dividend_c = bus.req_dividend_in[winner_c];
  assign sel_divisor_c  = bus.req_divisor_in[winner_c];
  assign mag_dividend_c = sel_dividend_c[WIDTH-1] ? -sel_dividend_c : sel_dividend_c;
  assign mag_divisor_c  = sel_divisor_c[WIDTH-1]  ? -sel_divisor_c  : sel_divisor_c;

  // Next-state and next-output logic
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    owner_d          = owner_q;
    neg_q_d          = neg_q_q;
    neg_r_d          = neg_r_q;
    timer_d          = timer_q;
    div_valid_d      = 1'b0;
    div_dividend_d   = div_dividend_q;
    div_divisor_d    = div_divisor_q;
    resp_valid_d     = '0;
    resp_quotient_d  = resp_quotient_q;
    resp_remainder_d = resp_remainder_q;
    resp_err_d       = resp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          owner_d      = winner_c;
          last_grant_d = winner_c;
          neg_q_d      = sel_dividend_c[WIDTH-1] ^ sel_divisor_c[WIDTH-1];
          neg_r_d      = sel_dividend_c[WIDTH-1];
          if (sel_divisor_c == '0) begin
            // Divide-by-zero answers directly, divider untouched
            state_d          = ST_RESP;
            resp_valid_d     = grant_oh_c;
            resp_quotient_d  = '0;
            resp_remainder_d = sel_dividend_c;
            resp_err_d       = 1'b1;
          end else begin
            // Start pulse and operands are registered for the ISSUE cycle
            state_d        = ST_ISSUE;
            div_valid_d    = 1'b1;
            div_dividend_d = mag_dividend_c;
            div_divisor_d  = mag_divisor_c;
          end
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.div_done_in) begin
          state_d          = ST_RESP;
          resp_valid_d     = owner_oh_c;
          resp_quotient_d  = neg_q_q ? -bus.div_quotient_in  : bus.div_quotient_in;
          resp_remainder_d = neg_r_q ? -bus.div_remainder_in : bus.div_remainder_in;
          resp_err_d       = 1'b0;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d          = ST_RESP;
          resp_valid_d     = owner_oh_c;
          resp_quotient_d  = '0;
          resp_remainder_d = '0;
          resp_err_d       = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q          <= ST_IDLE;
      last_grant_q     <= IDX_W'(LAST_IDX);
      owner_q          <= '0;
      neg_q_q          <= 1'b0;
      neg_r_q          <= 1'b0;
      timer_q          <= '0;
      div_valid_q      <= 1'b0;
      div_dividend_q   <= '0;
      div_divisor_q    <= '0;
      resp_valid_q     <= '0;
      resp_quotient_q  <= '0;
      resp_remainder_q <= '0;
      resp_err_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      owner_q          <= owner_d;
      neg_q_q          <= neg_q_d;
      neg_r_q          <= neg_r_d;
      timer_q          <= timer_d;
      div_valid_q      <= div_valid_d;
      div_dividend_q   <= div_dividend_d;
      div_divisor_q    <= div_divisor_d;
      resp_valid_q     <= resp_valid_d;
      resp_quotient_q  <= resp_quotient_d;
      resp_remainder_q <= resp_remainder_d;
      resp_err_q       <= resp_err_d;
    end
  end

  assign bus.div_valid_out      = div_valid_q;
  assign bus.div_dividend_out   = div_dividend_q;
  assign bus.div_divisor_out    = div_divisor_q;
  assign bus.resp_valid_out     = resp_valid_q;
  assign bus.resp_quotient_out  = resp_quotient_q;
  assign bus.resp_remainder_out = resp_remainder_q;
  assign bus.resp_err_out       = resp_err_q;

endmodule
